jtopl_wrqueue: RTL and testbench



---
 rtl/jtopl_wrqueue.sv | 232 +++++++++++++++++++++++
 tb/tb_jtopl_wrqueue.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtopl_wrqueue.sv
// jtopl_wrqueue -- CPU-side write queue and bus sequencer for jtopl chips.
//
// Register writes {chip, reg, data} are buffered in a FIFO and replayed on
// the chip bus as an address-port write followed by a data-port write, each
// followed by a cen-counted recovery gap (AW_WAIT / DW_WAIT cen pulses).
//
// Optional build macro: JTOPL_WRQ_SKIPADDR_EN
//   When defined, the last address written to each chip is remembered and a
//   write whose register matches it skips the address cycle entirely.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   cen             clock enable pacing the chip bus (tie to 1 if unused)
//   wr_valid/ready  host write handshake (ready = FIFO not full, ignores cen)
//   wr_chip/reg/data  write descriptor
//   level           FIFO occupancy
//   busy            FIFO non-empty or sequencer active
//   bad_chip        one-clk pulse when an entry with chip >= CHIPS is dropped
//   cs_n, wr_n      per-chip select and write strobe, active low, registered
//   addr, din       port select (0 = address, 1 = data) and bus data
//
// State table:
//   state    | meaning
//   IDLE     | waiting for a queued entry
//   DROP     | head entry targets a missing chip, discard it
//   ADDR     | address-port strobe asserted
//   AWAIT    | address recovery gap
//   DATA     | data-port strobe asserted
//   DWAIT    | data recovery gap, pops the head on exit

module jtopl_wrqueue #(
  parameter int CHIPS   = 2,
  parameter int DEPTH   = 16,
  parameter int AW_WAIT = 12,
  parameter int DW_WAIT = 84,
  parameter int CW      = (CHIPS > 1) ? $clog2(CHIPS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cen,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [CW-1:0]            wr_chip,
  input  logic [7:0]               wr_reg,
  input  logic [7:0]               wr_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic                     bad_chip,
  output logic [CHIPS-1:0]         cs_n,
  output logic                     wr_n,
  output logic                     addr,
  output logic [7:0]               din
);

  localparam int PW   = $clog2(DEPTH);
  localparam int LW   = PW + 1;
  localparam int EW   = CW + 16;
  localparam int WMAX = (AW_WAIT > DW_WAIT) ? AW_WAIT : DW_WAIT;
  localparam int TW   = (WMAX > 1) ? $clog2(WMAX) : 1;
  // A state occupies load+1 cen periods; a zero wait still costs one period.
  localparam logic [TW-1:0] AW_LOAD = (AW_WAIT > 0) ? TW'(AW_WAIT - 1) : '0;
  localparam logic [TW-1:0] DW_LOAD = (DW_WAIT > 0) ? TW'(DW_WAIT - 1) : '0;
  localparam logic [CW:0]   CHIPS_L = (CW + 1)'(CHIPS);

  typedef enum logic [2:0] {
    ST_IDLE, ST_DROP, ST_ADDR, ST_AWAIT, ST_DATA, ST_DWAIT
  } state_t;

  state_t state, state_nxt;

  // ---------------------------------------------------------------- FIFO
  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;

  assign wr_ready = (level != LW'(DEPTH));
  assign push     = wr_valid && wr_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {wr_chip, wr_reg, wr_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      level <= level + LW'(push) - LW'(pop);
    end
  end

  // ------------------------------------------------- entry being launched
  // On DWAIT exit the head is popped in the same edge, so the next launch
  // must look one slot ahead; everywhere else the head is the entry.
  logic [EW-1:0] head_ent, next_ent, l_ent;
  logic [CW-1:0] l_chip;
  logic [7:0]    l_reg, l_data;
  logic          l_bad, skip, launch;

  assign head_ent = mem[rd_ptr];
  assign next_ent = mem[rd_ptr + PW'(1)];
  assign l_ent    = (state == ST_DWAIT) ? next_ent : head_ent;
  assign l_chip   = l_ent[EW-1 -: CW];
  assign l_reg    = l_ent[15:8];
  assign l_data   = l_ent[7:0];
  assign l_bad    = ({1'b0, l_chip} >= CHIPS_L);

`ifdef JTOPL_WRQ_SKIPADDR_EN
  logic [7:0]       last_reg [CHIPS];
  logic [CHIPS-1:0] last_vld;

  assign skip = last_vld[l_chip] && (last_reg[l_chip] == l_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_vld <= '0;
      for (int i = 0; i < CHIPS; i++) last_reg[i] <= '0;
    end else if (launch && !skip) begin
      last_vld[l_chip] <= 1'b1;
      last_reg[l_chip] <= l_reg;
    end
  end
`else
  assign skip = 1'b0;
`endif

  // ------------------------------------------------------------- sequencer
  logic [TW-1:0]    cnt, cnt_nxt;
  logic [CHIPS-1:0] cs_n_nxt;
  logic             wr_n_nxt, addr_nxt, bad_nxt;
  logic [7:0]       din_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cs_n_nxt  = cs_n;
    wr_n_nxt  = wr_n;
    addr_nxt  = addr;
    din_nxt   = din;
    pop       = 1'b0;
    bad_nxt   = 1'b0;
    launch    = 1'b0;
    if (cen) begin
      case (state)
        ST_IDLE: begin
          if (level != '0) begin
            if (l_bad) state_nxt = ST_DROP;
            else       launch    = 1'b1;
          end
        end
        ST_DROP: begin
          pop       = 1'b1;
          bad_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end
        ST_ADDR: begin
          cs_n_nxt  = '1;
          wr_n_nxt  = 1'b1;
          cnt_nxt   = AW_LOAD;
          state_nxt = ST_AWAIT;
        end
        ST_AWAIT: begin
          if (cnt == '0) begin
            state_nxt = ST_DATA;
            cs_n_nxt  = ~(CHIPS'(1) << l_chip);
            wr_n_nxt  = 1'b0;
            addr_nxt  = 1'b1;
            din_nxt   = l_data;
          end else begin
            cnt_nxt = cnt - TW'(1);
          end
        end
        ST_DATA: begin
          cs_n_nxt  = '1;
          wr_n_nxt  = 1'b1;
          cnt_nxt   = DW_LOAD;
          state_nxt = ST_DWAIT;
        end
        ST_DWAIT: begin
          if (cnt == '0) begin
            pop       = 1'b1;
            state_nxt = ST_IDLE;
            // A bad follower is left for IDLE to route through DROP.
            if (level > LW'(1) && !l_bad) launch = 1'b1;
          end else begin
            cnt_nxt = cnt - TW'(1);
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
      if (launch) begin
        cs_n_nxt = ~(CHIPS'(1) << l_chip);
        wr_n_nxt = 1'b0;
        if (skip) begin
          state_nxt = ST_DATA;
          addr_nxt  = 1'b1;
          din_nxt   = l_data;
        end else begin
          state_nxt = ST_ADDR;
          addr_nxt  = 1'b0;
          din_nxt   = l_reg;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      cs_n     <= '1;
      wr_n     <= 1'b1;
      addr     <= 1'b0;
      din      <= '0;
      bad_chip <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      cs_n     <= cs_n_nxt;
      wr_n     <= wr_n_nxt;
      addr     <= addr_nxt;
      din      <= din_nxt;
      bad_chip <= bad_nxt;
    end
  end

  assign busy = (level != '0) || (state != ST_IDLE);

endmodule

// File: tb/tb_jtopl_wrqueue.sv
// Directed bench for jtopl_wrqueue. The main instance uses default
// parameters; a second, small instance with CHIPS=3 exercises the
// missing-chip drop path (chip index 3 needs a 2-bit chip field).
module tb_jtopl_wrqueue;

  logic       clk = 1'b0;
  logic       rst;
  logic       cen;
  logic       cen_slow = 1'b0;
  logic [1:0] phase = 2'd0;

  logic       wr_valid, wr_ready;
  logic       wr_chip;
  logic [7:0] wr_reg, wr_data;
  logic [4:0] level;
  logic       busy, bad_chip;
  logic [1:0] cs_n;
  logic       wr_n, addr;
  logic [7:0] din;

  logic       b_wr_valid, b_wr_ready;
  logic [1:0] b_wr_chip;
  logic [7:0] b_wr_reg, b_wr_data;
  logic [2:0] b_level;
  logic       b_busy, b_bad;
  logic [2:0] b_cs_n;
  logic       b_wr_n, b_addr;
  logic [7:0] b_din;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(negedge clk) phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
  assign cen = !cen_slow || (phase == 2'd0);

  jtopl_wrqueue dut (
    .clk(clk), .rst(rst), .cen(cen),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_chip(wr_chip), .wr_reg(wr_reg), .wr_data(wr_data),
    .level(level), .busy(busy), .bad_chip(bad_chip),
    .cs_n(cs_n), .wr_n(wr_n), .addr(addr), .din(din)
  );

  jtopl_wrqueue #(.CHIPS(3), .DEPTH(4), .AW_WAIT(1), .DW_WAIT(2)) dut_b (
    .clk(clk), .rst(rst), .cen(cen),
    .wr_valid(b_wr_valid), .wr_ready(b_wr_ready),
    .wr_chip(b_wr_chip), .wr_reg(b_wr_reg), .wr_data(b_wr_data),
    .level(b_level), .busy(b_busy), .bad_chip(b_bad),
    .cs_n(b_cs_n), .wr_n(b_wr_n), .addr(b_addr), .din(b_din)
  );

  // Cycle and cen-pulse counters, counted at the edge the DUT uses.
  int cyc = 0;
  int cen_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cen) cen_cnt <= cen_cnt + 1;
  end

  // Strobe log for the main instance.
  int         n_s = 0;
  int         cur_w = 0;
  logic       wr_n_q = 1'b1;
  logic [7:0] s_din [128];
  logic       s_addr [128];
  logic [1:0] s_cs [128];
  int         s_cen [128];
  int         s_cyc [128];
  int         s_w [128];

  always @(negedge clk) begin
    if (!wr_n && wr_n_q) begin
      if (n_s < 128) begin
        s_din[n_s]  <= din;
        s_addr[n_s] <= addr;
        s_cs[n_s]   <= cs_n;
        s_cen[n_s]  <= cen_cnt;
        s_cyc[n_s]  <= cyc;
        n_s         <= n_s + 1;
      end
      cur_w <= 1;
    end else if (!wr_n) begin
      cur_w <= cur_w + 1;
    end else if (!wr_n_q && n_s > 0) begin
      s_w[n_s-1] <= cur_w;
    end
    wr_n_q <= wr_n;
  end

  // Strobe and bad_chip log for the small instance.
  int         b_n = 0;
  int         b_bad_n = 0;
  logic       b_wr_n_q = 1'b1;
  logic [7:0] b_din_l [8];
  logic       b_addr_l [8];
  logic [2:0] b_cs_l [8];

  always @(negedge clk) begin
    if (!b_wr_n && b_wr_n_q && b_n < 8) begin
      b_din_l[b_n]  <= b_din;
      b_addr_l[b_n] <= b_addr;
      b_cs_l[b_n]   <= b_cs_n;
      b_n           <= b_n + 1;
    end
    b_wr_n_q <= b_wr_n;
    if (b_bad) b_bad_n <= b_bad_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_main(input logic ch, input logic [7:0] r, input logic [7:0] d,
                           output int waited);
    @(negedge clk);
    wr_valid = 1'b1; wr_chip = ch; wr_reg = r; wr_data = d;
    waited = 0;
    while (!wr_ready && waited < 20000) begin
      @(negedge clk);
      waited++;
    end
    check("push_wait_bound", {31'b0, waited < 20000}, 32'd1);
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, base, snap, ne;
    logic [7:0] e_din [6];
    logic       e_addr [6];

    rst = 1'b1;
    wr_valid = 1'b0; wr_chip = 1'b0; wr_reg = '0; wr_data = '0;
    b_wr_valid = 1'b0; b_wr_chip = '0; b_wr_reg = '0; b_wr_data = '0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_cs_n", {30'b0, cs_n}, 32'h3);
    check("rst_wr_n", {31'b0, wr_n}, 32'd1);
    check("rst_addr", {31'b0, addr}, 32'd0);
    check("rst_din", {24'b0, din}, 32'd0);
    check("rst_level", {27'b0, level}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_bad", {31'b0, bad_chip}, 32'd0);
    check("rst_ready", {31'b0, wr_ready}, 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single write: chip 1, reg 0x20, data 0x41, push at edge 0
    wr_valid = 1'b1; wr_chip = 1'b1; wr_reg = 8'h20; wr_data = 8'h41;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    check("t1_level_e0", {27'b0, level}, 32'd1);
    check("t1_busy_e0", {31'b0, busy}, 32'd1);
    @(posedge clk); #1;
    check("t1_addr_cs", {30'b0, cs_n}, 32'h1);
    check("t1_addr_wr", {31'b0, wr_n}, 32'd0);
    check("t1_addr_port", {31'b0, addr}, 32'd0);
    check("t1_addr_din", {24'b0, din}, 32'h20);
    @(posedge clk); #1;
    check("t1_await_wr", {31'b0, wr_n}, 32'd1);
    check("t1_await_cs", {30'b0, cs_n}, 32'h3);
    check("t1_await_din_hold", {24'b0, din}, 32'h20);
    repeat (12) @(posedge clk); #1;
    check("t1_data_cs", {30'b0, cs_n}, 32'h1);
    check("t1_data_wr", {31'b0, wr_n}, 32'd0);
    check("t1_data_port", {31'b0, addr}, 32'd1);
    check("t1_data_din", {24'b0, din}, 32'h41);
    @(posedge clk); #1;
    check("t1_dwait_wr", {31'b0, wr_n}, 32'd1);
    check("t1_dwait_addr_hold", {31'b0, addr}, 32'd1);
    check("t1_dwait_din_hold", {24'b0, din}, 32'h41);
    repeat (83) @(posedge clk); #1;
    check("t1_busy_e98", {31'b0, busy}, 32'd1);
    @(posedge clk); #1;
    check("t1_busy_e99", {31'b0, busy}, 32'd0);
    check("t1_level_end", {27'b0, level}, 32'd0);

    // Burst of 20 into a 16-deep queue
    base = n_s;
    for (int i = 0; i < 20; i++) begin
      push_main(i[0], i[7:0], 8'h80 + i[7:0], w);
      if (i == 15) begin
        check("burst_full_level", {27'b0, level}, 32'd16);
        check("burst_full_ready", {31'b0, wr_ready}, 32'd0);
      end
      if (i == 16) begin
        check("burst_held_off", {31'b0, w > 0}, 32'd1);
        check("burst_refill_level", {27'b0, level}, 32'd16);
      end
    end
    wait_idle("burst_idle", 5000);
    check("burst_strobes", n_s - base, 32'd40);
    for (int j = 0; j < 20; j++) begin
      check("burst_a_port", {31'b0, s_addr[base+2*j]}, 32'd0);
      check("burst_a_din", {24'b0, s_din[base+2*j]}, j);
      check("burst_a_cs", {30'b0, s_cs[base+2*j]}, j[0] ? 32'h1 : 32'h2);
      check("burst_d_port", {31'b0, s_addr[base+2*j+1]}, 32'd1);
      check("burst_d_din", {24'b0, s_din[base+2*j+1]}, 32'h80 + j);
      if (j > 0)
        check("burst_spacing", s_cen[base+2*j] - s_cen[base+2*j-2], 32'd98);
    end

    // cen active one clk in three
    cen_slow = 1'b1;
    base = n_s;
    push_main(1'b0, 8'h40, 8'h50, w);
    push_main(1'b1, 8'h41, 8'h51, w);
    push_main(1'b0, 8'h42, 8'h52, w);
    wait_idle("cen3_idle", 3000);
    @(negedge clk);
    check("cen3_strobes", n_s - base, 32'd6);
    for (int j = 0; j < 3; j++) begin
      check("cen3_a_din", {24'b0, s_din[base+2*j]}, 32'h40 + j);
      check("cen3_d_din", {24'b0, s_din[base+2*j+1]}, 32'h50 + j);
      check("cen3_a_width", s_w[base+2*j], 32'd3);
      check("cen3_d_width", s_w[base+2*j+1], 32'd3);
      check("cen3_a_to_d", s_cyc[base+2*j+1] - s_cyc[base+2*j], 32'd39);
      if (j > 0)
        check("cen3_a_to_a", s_cyc[base+2*j] - s_cyc[base+2*j-2], 32'd294);
    end
    cen_slow = 1'b0;

    // Missing chip on the CHIPS=3 instance, then a good entry
    @(negedge clk);
    b_wr_valid = 1'b1; b_wr_chip = 2'd3; b_wr_reg = 8'h77; b_wr_data = 8'h88;
    @(negedge clk);
    b_wr_chip = 2'd2; b_wr_reg = 8'h55; b_wr_data = 8'h66;
    @(negedge clk);
    b_wr_valid = 1'b0;
    w = 0;
    while (b_busy && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("bad_idle", {31'b0, b_busy}, 32'd0);
    check("bad_pulses", b_bad_n, 32'd1);
    check("bad_strobes", b_n, 32'd2);
    check("bad_a_port", {31'b0, b_addr_l[0]}, 32'd0);
    check("bad_a_din", {24'b0, b_din_l[0]}, 32'h55);
    check("bad_a_cs", {29'b0, b_cs_l[0]}, 32'h3);
    check("bad_d_port", {31'b0, b_addr_l[1]}, 32'd1);
    check("bad_d_din", {24'b0, b_din_l[1]}, 32'h66);
    check("bad_d_cs", {29'b0, b_cs_l[1]}, 32'h3);
    check("bad_level", {29'b0, b_level}, 32'd0);

    // Reset during AWAIT with entries queued
    push_main(1'b0, 8'h60, 8'h61, w);
    push_main(1'b1, 8'h62, 8'h63, w);
    push_main(1'b0, 8'h64, 8'h65, w);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_await_cs", {30'b0, cs_n}, 32'h3);
    check("rst_await_wr", {31'b0, wr_n}, 32'd1);
    check("rst_await_level", {27'b0, level}, 32'd0);
    check("rst_await_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    // Reset landing inside a live strobe
    push_main(1'b1, 8'h66, 8'h67, w);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_strobe_wr", {31'b0, wr_n}, 32'd1);
    check("rst_strobe_cs", {30'b0, cs_n}, 32'h3);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    snap = n_s;
    repeat (300) @(negedge clk);
    check("rst_no_strobe", n_s - snap, 32'd0);
    check("rst_idle_busy", {31'b0, busy}, 32'd0);

    // Repeated register address to the same chip
    base = n_s;
    push_main(1'b0, 8'hA0, 8'h11, w);
    push_main(1'b0, 8'hA0, 8'h22, w);
    push_main(1'b0, 8'hB0, 8'h33, w);
    wait_idle("skip_idle", 1000);
    @(negedge clk);
`ifdef JTOPL_WRQ_SKIPADDR_EN
    ne = 5;
    e_addr[0] = 1'b0; e_din[0] = 8'hA0;
    e_addr[1] = 1'b1; e_din[1] = 8'h11;
    e_addr[2] = 1'b1; e_din[2] = 8'h22;
    e_addr[3] = 1'b0; e_din[3] = 8'hB0;
    e_addr[4] = 1'b1; e_din[4] = 8'h33;
    e_addr[5] = 1'b0; e_din[5] = 8'h00;
`else
    ne = 6;
    e_addr[0] = 1'b0; e_din[0] = 8'hA0;
    e_addr[1] = 1'b1; e_din[1] = 8'h11;
    e_addr[2] = 1'b0; e_din[2] = 8'hA0;
    e_addr[3] = 1'b1; e_din[3] = 8'h22;
    e_addr[4] = 1'b0; e_din[4] = 8'hB0;
    e_addr[5] = 1'b1; e_din[5] = 8'h33;
`endif
    check("skip_strobes", n_s - base, ne);
    for (int j = 0; j < ne; j++) begin
      check("skip_port", {31'b0, s_addr[base+j]}, {31'b0, e_addr[j]});
      check("skip_din", {24'b0, s_din[base+j]}, {24'b0, e_din[j]});
      check("skip_cs", {30'b0, s_cs[base+j]}, 32'h2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
